// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: base opcode encoding shared by alu_seq and its users.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_opcode_t;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: valid/ready execute unit; single-cycle base ALU plus an iterative radix-2
// RV M-extension datapath compiled in only when ALU_MD_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  alu_opcode_t     i_alu_op,
  input  logic            i_is_md,
  input  logic [2:0]      i_md_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] base_res_c;
  logic [SHW-1:0]  shamt_c;
  logic            accept_c;

  assign shamt_c  = i_op2[SHW-1:0];
  assign accept_c = i_valid && o_ready;
  assign o_valid  = valid_q;
  assign o_result = result_q;

  always_comb begin
    base_res_c = '0;
    case (i_alu_op)
      ALU_ADD:  base_res_c = i_op1 + i_op2;
      ALU_SUB:  base_res_c = i_op1 - i_op2;
      ALU_SLL:  base_res_c = i_op1 << shamt_c;
      ALU_SLT:  base_res_c = XLEN'($signed(i_op1) < $signed(i_op2));
      ALU_SLTU: base_res_c = XLEN'(i_op1 < i_op2);
      ALU_XOR:  base_res_c = i_op1 ^ i_op2;
      ALU_SRL:  base_res_c = i_op1 >> shamt_c;
      ALU_SRA:  base_res_c = XLEN'($signed(i_op1) >>> shamt_c);
      ALU_OR:   base_res_c = i_op1 | i_op2;
      ALU_AND:  base_res_c = i_op1 & i_op2;
      default:  base_res_c = '0;
    endcase
  end

`ifdef ALU_MD_EN
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e          state_q;
  logic            busy_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] a_q;
  logic [PW-1:0]   prod_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            rneg_q;
  logic            div0_q;

  logic            op1_s_c, op2_s_c, neg1_c, neg2_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic [XLEN:0]   mul_sum_c;
  logic [PW-1:0]   mul_nx_c, mul_fix_c;
  logic [XLEN:0]   rem_sh_c;
  logic            div_ge_c;
  logic [XLEN-1:0] rem_nx_c, quo_nx_c, quo_fix_c, rem_fix_c, md_res_c;

  assign o_ready = (state_q == S_IDLE) && (!valid_q || i_ready);
  assign o_busy  = busy_q;

  // Operand signedness per funct3; magnitudes feed the unsigned iterative core
  always_comb begin
    op1_s_c = 1'b0;
    op2_s_c = 1'b0;
    case (i_md_op)
      3'd1, 3'd4, 3'd6: begin
        op1_s_c = 1'b1;
        op2_s_c = 1'b1;
      end
      3'd2:    op1_s_c = 1'b1;
      default: ;
    endcase
  end

  assign neg1_c = op1_s_c & i_op1[XLEN-1];
  assign neg2_c = op2_s_c & i_op2[XLEN-1];
  assign mag1_c = neg1_c ? -i_op1 : i_op1;
  assign mag2_c = neg2_c ? -i_op2 : i_op2;

  // Shift-add step: prod_q = {partial high, remaining multiplier bits}
  assign mul_sum_c = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign mul_nx_c  = {mul_sum_c, prod_q[XLEN-1:1]};
  assign mul_fix_c = neg_q ? -mul_nx_c : mul_nx_c;

  // Restoring step: prod_q = {partial remainder, dividend/quotient}
  assign rem_sh_c  = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
  assign div_ge_c  = rem_sh_c >= {1'b0, a_q};
  assign rem_nx_c  = div_ge_c ? XLEN'(rem_sh_c - {1'b0, a_q}) : XLEN'(rem_sh_c);
  assign quo_nx_c  = {prod_q[XLEN-2:0], div_ge_c};
  assign quo_fix_c = div0_q ? '1 : (neg_q ? -quo_nx_c : quo_nx_c);
  assign rem_fix_c = rneg_q ? -rem_nx_c : rem_nx_c;

  always_comb begin
    md_res_c = '0;
    if (state_q == S_MUL) begin
      md_res_c = (op_q == 3'd0) ? mul_fix_c[XLEN-1:0] : mul_fix_c[PW-1:XLEN];
    end else begin
      md_res_c = op_q[1] ? rem_fix_c : quo_fix_c;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      prod_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (valid_q && i_ready) valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c && !i_is_md) begin
            valid_q  <= 1'b1;
            result_q <= base_res_c;
          end else if (accept_c) begin
            busy_q <= 1'b1;
            cnt_q  <= SHW'(XLEN - 1);
            op_q   <= i_md_op;
            neg_q  <= neg1_c ^ neg2_c;
            rneg_q <= neg1_c;
            div0_q <= (i_op2 == '0);
            if (i_md_op[2]) begin
              state_q <= S_DIV;
              a_q     <= mag2_c;
              prod_q  <= {{XLEN{1'b0}}, mag1_c};
            end else begin
              state_q <= S_MUL;
              a_q     <= mag1_c;
              prod_q  <= {{XLEN{1'b0}}, mag2_c};
            end
          end
        end
        S_MUL, S_DIV: begin
          prod_q <= (state_q == S_MUL) ? mul_nx_c : {rem_nx_c, quo_nx_c};
          cnt_q  <= cnt_q - SHW'(1);
          // Last step also sign-corrects and publishes the result
          if (cnt_q == '0) begin
            cnt_q    <= '0;
            result_q <= md_res_c;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_md_c;

  assign unused_md_c = ^i_md_op;
  assign o_ready     = !valid_q || i_ready;
  assign o_busy      = 1'b0;

  // Without the M datapath, M requests complete like base ops with a zero result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else begin
      if (valid_q && i_ready) valid_q <= 1'b0;
      if (accept_c) begin
        valid_q  <= 1'b1;
        result_q <= i_is_md ? '0 : base_res_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (M-extension steps run when ALU_MD_EN is defined).
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, ivalid, oready, ismd, ovalid, iready, obusy;
  logic [XLEN-1:0] op1, op2, oresult;
  logic [2:0]      mdop;
  alu_opcode_t     aluop;

  int              n_assert = 0;
  int              n_fail   = 0;
  logic [31:0]     exp_q[$];
  logic [31:0]     cur_exp;

  alu_seq #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(ivalid), .o_ready(oready),
    .i_op1(op1), .i_op2(op2), .i_alu_op(aluop), .i_is_md(ismd), .i_md_op(mdop),
    .o_valid(ovalid), .i_ready(iready), .o_result(oresult), .o_busy(obusy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:       ref_alu = a + b;
      1:       ref_alu = a - b;
      2:       ref_alu = a << b[4:0];
      3:       ref_alu = {31'b0, $signed(a) < $signed(b)};
      4:       ref_alu = {31'b0, a < b};
      5:       ref_alu = a ^ b;
      6:       ref_alu = a >> b[4:0];
      7:       ref_alu = 32'($signed(a) >>> b[4:0]);
      8:       ref_alu = a | b;
      9:       ref_alu = a & b;
      default: ref_alu = '0;
    endcase
  endfunction

  // One clock: score consumed results, record accepted requests, advance to next negedge
  task automatic tick(output bit acc);
    logic [31:0] e;
    #1;
    acc = ivalid && oready && !flush && !rst;
    if (ovalid && iready && !flush && !rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(ovalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", oresult, e);
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic md, input logic [2:0] mop, input alu_opcode_t aop,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int lat_exp);
    bit acc;
    bit rdy_bad;
    int lat;
    ismd = md; mdop = mop; aluop = aop; op1 = a; op2 = b; cur_exp = exp;
    ivalid = 1'b1; iready = 1'b1;
    lat = 0;
    do begin
      tick(acc);
      lat++;
    end while (!acc && lat < 50);
    ivalid = 1'b0;
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    lat = 1;
    rdy_bad = 1'b0;
    #1;
    while (!ovalid && lat < 100) begin
      if (oready !== 1'b0 || obusy !== 1'b1) rdy_bad = 1'b1;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    if (lat_exp > 1) chk({tag, "_busy_rdy"}, 32'(rdy_bad), 32'd0);
    tick(acc);
  endtask

  initial begin
    bit acc;
    int nv;
    rst = 1'b1; flush = 1'b0; ivalid = 1'b0; iready = 1'b1; ismd = 1'b0;
    mdop = 3'd0; aluop = ALU_ADD; op1 = '0; op2 = '0; cur_exp = '0;
    @(negedge clk);
    tick(acc);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(ovalid), 32'd0);
    chk("rst_busy", 32'(obusy), 32'd0);
    chk("rst_result", oresult, 32'd0);
    chk("rst_ready", 32'(oready), 32'd1);
    @(negedge clk);

    // Base ops
    run_op("add_wrap", 1'b0, 3'd0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("sra", 1'b0, 3'd0, ALU_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("slt", 1'b0, 3'd0, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
    run_op("sltu", 1'b0, 3'd0, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("sll", 1'b0, 3'd0, ALU_SLL, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 1);
    run_op("srl", 1'b0, 3'd0, ALU_SRL, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1);
    run_op("sub", 1'b0, 3'd0, ALU_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1);
    run_op("undef_op", 1'b0, 3'd0, alu_opcode_t'(4'hF), 32'h1234, 32'h5678, 32'h0, 1);

    // Back-to-back stream: one accept and one result per cycle
    iready = 1'b1; ivalid = 1'b1; ismd = 1'b0; nv = 0;
    for (int i = 0; i < 10; i++) begin
      op1 = $urandom; op2 = $urandom; aluop = alu_opcode_t'(i);
      cur_exp = ref_alu(i, op1, op2);
      #1;
      if (ovalid) nv++;
      tick(acc);
      chk("b2b_acc", 32'(acc), 32'd1);
    end
    ivalid = 1'b0;
    #1;
    if (ovalid) nv++;
    tick(acc);
    chk("b2b_valid_cycles", 32'(nv), 32'd10);

    // Backpressure: result held, next request stalls, release consumes and accepts together
    ismd = 1'b0; aluop = ALU_ADD; op1 = 32'h1234_0000; op2 = 32'h0000_5678;
    cur_exp = 32'h1234_5678; ivalid = 1'b1; iready = 1'b0;
    tick(acc);
    chk("bp_acc", 32'(acc), 32'd1);
    aluop = ALU_XOR; op1 = 32'hF0F0_F0F0; op2 = 32'h0FF0_0FF0; cur_exp = 32'hFF00_FF00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(ovalid), 32'd1);
      chk("bp_hold", oresult, 32'h1234_5678);
      chk("bp_ready", 32'(oready), 32'd0);
      tick(acc);
    end
    iready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(oready), 32'd1);
    tick(acc);
    chk("bp_release_acc", 32'(acc), 32'd1);
    ivalid = 1'b0;
    #1;
    chk("bp_second_valid", 32'(ovalid), 32'd1);
    tick(acc);

    // Flush discards a same-cycle accept, and a pending result without clearing o_result
    ivalid = 1'b1; aluop = ALU_ADD; op1 = 32'd1; op2 = 32'd1; cur_exp = 32'd2; flush = 1'b1;
    tick(acc);
    flush = 1'b0; ivalid = 1'b0;
    #1;
    chk("flush_acc_drop", 32'(ovalid), 32'd0);
    chk("flush_acc_ready", 32'(oready), 32'd1);
    @(negedge clk);
    ivalid = 1'b1; iready = 1'b0; op1 = 32'd40; op2 = 32'd2; cur_exp = 32'd42;
    tick(acc);
    ivalid = 1'b0; flush = 1'b1;
    tick(acc);
    flush = 1'b0; exp_q.delete();
    #1;
    chk("flush_pend_valid", 32'(ovalid), 32'd0);
    chk("flush_pend_result", oresult, 32'd42);
    @(negedge clk);

    // Reset with a pending result
    ivalid = 1'b1; iready = 1'b0; op1 = 32'd5; op2 = 32'd6; cur_exp = 32'd11;
    tick(acc);
    ivalid = 1'b0; rst = 1'b1;
    tick(acc);
    rst = 1'b0; exp_q.delete(); iready = 1'b1;
    #1;
    chk("rst_pend_valid", 32'(ovalid), 32'd0);
    chk("rst_pend_result", oresult, 32'd0);
    chk("rst_pend_busy", 32'(obusy), 32'd0);
    @(negedge clk);

`ifdef ALU_MD_EN
    run_op("mulh", 1'b1, 3'd1, ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu", 1'b1, 3'd3, ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul", 1'b1, 3'd0, ALU_ADD, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhsu", 1'b1, 3'd2, ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_by0", 1'b1, 3'd4, ALU_ADD, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("rem_by0", 1'b1, 3'd6, ALU_ADD, 32'd7, 32'd0, 32'd7, 33);
    run_op("div_ovf", 1'b1, 3'd4, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("rem_ovf", 1'b1, 3'd6, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("div_neg", 1'b1, 3'd4, ALU_ADD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_neg", 1'b1, 3'd6, ALU_ADD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 1'b1, 3'd5, ALU_ADD, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 1'b1, 3'd7, ALU_ADD, 32'd100, 32'd7, 32'd2, 33);

    // Flush in cycle 10 of a DIVU
    ismd = 1'b1; mdop = 3'd5; op1 = 32'd1000; op2 = 32'd3; cur_exp = 32'd333; ivalid = 1'b1;
    tick(acc);
    chk("fdiv_acc", 32'(acc), 32'd1);
    ivalid = 1'b0;
    for (int i = 1; i < 10; i++) tick(acc);
    flush = 1'b1;
    tick(acc);
    flush = 1'b0; exp_q.delete();
    #1;
    chk("fdiv_valid", 32'(ovalid), 32'd0);
    chk("fdiv_ready", 32'(oready), 32'd1);
    chk("fdiv_busy", 32'(obusy), 32'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (ovalid) nv++;
    end
    chk("fdiv_no_result", 32'(nv), 32'd0);
    @(negedge clk);
    run_op("add_after_flush", 1'b0, 3'd0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1);

    // Reset mid-MUL
    ismd = 1'b1; mdop = 3'd0; op1 = 32'd3; op2 = 32'd4; cur_exp = 32'd12; ivalid = 1'b1;
    tick(acc);
    ivalid = 1'b0;
    for (int i = 0; i < 5; i++) tick(acc);
    chk("rmul_busy_before", 32'(obusy), 32'd1);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0; exp_q.delete();
    #1;
    chk("rmul_valid", 32'(ovalid), 32'd0);
    chk("rmul_busy", 32'(obusy), 32'd0);
    chk("rmul_result", oresult, 32'd0);
    @(negedge clk);
`else
    run_op("nomd_mul", 1'b1, 3'd0, ALU_ADD, 32'd3, 32'd4, 32'd0, 1);
    chk("nomd_busy", 32'(obusy), 32'd0);
    run_op("nomd_div", 1'b1, 3'd4, ALU_ADD, 32'd9, 32'd3, 32'd0, 1);
    run_op("add_after_md", 1'b0, 3'd0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
